// File: rtl/riscv_pkg.sv
// Shared RV32 core definitions: fetch FSM states, the fetch packet, and the
// immediate-select encodings that decode hands to the extender.
package riscv_pkg;

    localparam int unsigned XLEN_W    = 32;
    localparam int unsigned INSTR_W   = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        FS_IDLE  = 3'd0,
        FS_REQ   = 3'd1,
        FS_WAIT  = 3'd2,
        FS_HOLD  = 3'd3,
        FS_DRAIN = 3'd4
    } fetch_state_e;

    typedef enum logic [1:0] {
        IMM_I = 2'd0,
        IMM_S = 2'd1,
        IMM_B = 2'd2,
        IMM_U = 2'd3
    } imm_sel_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [XLEN_W-1:0]  pc;
    } fetch_pkt_t;

    // Fetch addresses are always word aligned; low bits of a target are dropped.
    function automatic logic [XLEN_W-1:0] word_align(input logic [XLEN_W-1:0] addr);
        return {addr[XLEN_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_hold_reg.sv
// Single-entry instruction/PC buffer that parks a returned word while the
// decode-facing output slot is still occupied.
module fetch_hold_reg
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear_i,
    input  logic       load_i,
    input  logic       unload_i,
    input  fetch_pkt_t pkt_i,
    output logic       valid_o,
    output fetch_pkt_t pkt_o
);

    logic       valid_q, valid_d;
    fetch_pkt_t pkt_q, pkt_d;

    // Clear wins over load so a redirect can never leave a stale entry behind.
    always_comb begin
        valid_d = valid_q;
        pkt_d   = pkt_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            pkt_d   = pkt_i;
        end else if (unload_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pkt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pkt_q   <= pkt_d;
        end
    end

    assign valid_o = valid_q;
    assign pkt_o   = pkt_q;

endmodule

// File: rtl/instr_fetch.sv
// RV32 fetch stage: owns the PC, issues one outstanding word request at a time
// and hands instructions to decode over a valid/ready slot.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            ImemReq,
    output logic [XLEN-1:0] ImemAddr,
    input  logic            ImemGnt,
    input  logic            ImemRvalid,
    input  logic [31:0]     ImemRdata,
    output logic [31:0]     Instr,
    output logic [XLEN-1:0] InstrPC,
    output logic            InstrValid,
    input  logic            InstrReady,
    input  logic            Redirect,
    input  logic [XLEN-1:0] RedirectPC
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, pc_inc;
    logic            req_q, req_d;
    logic            out_valid_q, out_valid_d;
    logic [31:0]     out_instr_q, out_instr_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;

    logic            hold_clear, hold_load, hold_unload, hold_valid;
    fetch_pkt_t      hold_pkt_in, hold_pkt;
    logic            xfer;

    assign xfer   = out_valid_q && InstrReady;
    assign pc_inc = pc_q + XLEN'(4);

    fetch_hold_reg u_hold (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (hold_clear),
        .load_i   (hold_load),
        .unload_i (hold_unload),
        .pkt_i    (hold_pkt_in),
        .valid_o  (hold_valid),
        .pkt_o    (hold_pkt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, PC and output slot; redirect is applied last so it overrides.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        hold_clear  = 1'b0;
        hold_load   = 1'b0;
        hold_unload = 1'b0;
        hold_pkt_in = '{instr: ImemRdata, pc: pc_q};

        if (xfer) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            FS_IDLE: begin
                state_d = FS_REQ;
            end
            FS_REQ: begin
                if (ImemGnt) begin
                    state_d = FS_WAIT;
                end
            end
            FS_WAIT: begin
                if (ImemRvalid) begin
                    pc_d = pc_inc;
                    if (!out_valid_q || InstrReady) begin
                        out_valid_d = 1'b1;
                        out_instr_d = ImemRdata;
                        out_pc_d    = pc_q;
                        state_d     = FS_REQ;
                    end else begin
                        hold_load = 1'b1;
                        state_d   = FS_HOLD;
                    end
                end
            end
            FS_HOLD: begin
                if (xfer && hold_valid) begin
                    hold_unload = 1'b1;
                    out_valid_d = 1'b1;
                    out_instr_d = hold_pkt.instr;
                    out_pc_d    = hold_pkt.pc;
                    state_d     = FS_REQ;
                end
            end
            FS_DRAIN: begin
                if (ImemRvalid) begin
                    state_d = FS_REQ;
                end
            end
            default: begin
                state_d = FS_IDLE;
            end
        endcase

        if (Redirect) begin
            pc_d        = word_align(RedirectPC);
            out_valid_d = 1'b0;
            out_instr_d = NOP_INSTR;
            hold_clear  = 1'b1;
            hold_load   = 1'b0;
            hold_unload = 1'b0;
            // A granted-but-unanswered request still owes a response to discard.
            case (state_q)
                FS_REQ:   state_d = ImemGnt    ? FS_DRAIN : FS_REQ;
                FS_WAIT:  state_d = ImemRvalid ? FS_REQ   : FS_DRAIN;
                FS_DRAIN: state_d = ImemRvalid ? FS_REQ   : FS_DRAIN;
                default:  state_d = FS_REQ;
            endcase
        end

        req_d = (state_d == FS_REQ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            req_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_instr_q <= NOP_INSTR;
            out_pc_q    <= '0;
        end else begin
            pc_q        <= pc_d;
            req_q       <= req_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
        end
    end

    assign ImemReq    = req_q;
    assign ImemAddr   = pc_q;
    assign Instr      = out_instr_q;
    assign InstrPC    = out_pc_q;
    assign InstrValid = out_valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a per-cycle vector table for streaming,
// back-pressure, redirect and wrap, then an async reset pulse mid-fetch.
module tb_instr_fetch;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] D0   = 32'h0050_0093;
    localparam logic [31:0] D1   = 32'h00A0_0113;
    localparam logic [31:0] D2   = 32'h00F0_0193;
    localparam logic [31:0] D3   = 32'h0140_0213;
    localparam logic [31:0] D4   = 32'h0190_0293;
    localparam logic [31:0] D5   = 32'h01E0_0313;
    localparam logic [31:0] D6   = 32'h0230_0393;
    localparam logic [31:0] D7   = 32'h0280_0413;
    localparam logic [31:0] BAD  = 32'hDEAD_BEEF;
    localparam logic [31:0] BPC  = 32'h8000_0000;

    logic        clk;
    logic        rst_n;
    logic        gnt, rvalid, ready, redir;
    logic [31:0] rdata, rpc;

    logic        a_req, a_valid, b_req, b_valid;
    logic [31:0] a_addr, a_instr, a_pc, b_addr, b_instr, b_pc;

    int n_cmp = 0;
    int n_bad = 0;

    instr_fetch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ImemReq    (a_req),
        .ImemAddr   (a_addr),
        .ImemGnt    (gnt),
        .ImemRvalid (rvalid),
        .ImemRdata  (rdata),
        .Instr      (a_instr),
        .InstrPC    (a_pc),
        .InstrValid (a_valid),
        .InstrReady (ready),
        .Redirect   (redir),
        .RedirectPC (rpc)
    );

    instr_fetch #(.RESET_PC(BPC)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .ImemReq    (b_req),
        .ImemAddr   (b_addr),
        .ImemGnt    (gnt),
        .ImemRvalid (rvalid),
        .ImemRdata  (rdata),
        .Instr      (b_instr),
        .InstrPC    (b_pc),
        .InstrValid (b_valid),
        .InstrReady (ready),
        .Redirect   (redir),
        .RedirectPC (rpc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          gnt, rv;
        logic [31:0] rdata;
        bit          rdy, rdr;
        logic [31:0] rpc;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_instr, e_pc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit g, bit rv, logic [31:0] rd, bit rdy, bit rdr,
                                logic [31:0] rp, bit ereq, logic [31:0] eaddr,
                                bit ev, logic [31:0] ei, logic [31:0] epc);
        vec_t v;
        v.gnt = g; v.rv = rv; v.rdata = rd; v.rdy = rdy; v.rdr = rdr; v.rpc = rp;
        v.e_req = ereq; v.e_addr = eaddr; v.e_valid = ev; v.e_instr = ei; v.e_pc = epc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_a(input string tag, input bit ereq, input logic [31:0] eaddr,
                         input bit ev, input logic [31:0] ei, input logic [31:0] epc);
        chk({tag, ".req"},   32'(a_req),   32'(ereq));
        chk({tag, ".addr"},  a_addr,       eaddr);
        chk({tag, ".valid"}, 32'(a_valid), 32'(ev));
        chk({tag, ".instr"}, a_instr,      ei);
        chk({tag, ".pc"},    a_pc,         epc);
    endtask

    task automatic drive(input bit g, input bit rv, input logic [31:0] rd, input bit rdy,
                         input bit rdr, input logic [31:0] rp);
        gnt = g; rvalid = rv; rdata = rd; ready = rdy; redir = rdr; rpc = rp;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 32'h0, 0, 0, 32'h0);

        //          gnt rv rdata rdy rdr rpc           req addr          v  instr pc
        tbl.push_back(mk(0, 0, 0,   1, 0, 0,           0, 32'h0000_0000, 0, NOP, 32'h0));          // c0 IDLE
        tbl.push_back(mk(1, 0, 0,   1, 0, 0,           1, 32'h0000_0000, 0, NOP, 32'h0));          // c1 REQ
        tbl.push_back(mk(0, 1, D0,  1, 0, 0,           0, 32'h0000_0000, 0, NOP, 32'h0));          // c2 WAIT
        tbl.push_back(mk(1, 0, 0,   1, 0, 0,           1, 32'h0000_0004, 1, D0,  32'h0));          // c3
        tbl.push_back(mk(0, 1, D1,  1, 0, 0,           0, 32'h0000_0004, 0, D0,  32'h0));          // c4
        tbl.push_back(mk(1, 0, 0,   1, 0, 0,           1, 32'h0000_0008, 1, D1,  32'h4));          // c5
        tbl.push_back(mk(0, 1, D2,  1, 0, 0,           0, 32'h0000_0008, 0, D1,  32'h4));          // c6
        tbl.push_back(mk(1, 0, 0,   0, 0, 0,           1, 32'h0000_000C, 1, D2,  32'h8));          // c7 stall starts
        tbl.push_back(mk(0, 1, D3,  0, 0, 0,           0, 32'h0000_000C, 1, D2,  32'h8));          // c8 -> HOLD
        tbl.push_back(mk(0, 0, 0,   0, 0, 0,           0, 32'h0000_0010, 1, D2,  32'h8));          // c9
        tbl.push_back(mk(0, 0, 0,   0, 0, 0,           0, 32'h0000_0010, 1, D2,  32'h8));
        tbl.push_back(mk(0, 0, 0,   0, 0, 0,           0, 32'h0000_0010, 1, D2,  32'h8));
        tbl.push_back(mk(0, 0, 0,   0, 0, 0,           0, 32'h0000_0010, 1, D2,  32'h8));          // c12
        tbl.push_back(mk(0, 0, 0,   1, 0, 0,           0, 32'h0000_0010, 1, D2,  32'h8));          // c13 release
        tbl.push_back(mk(1, 0, 0,   1, 0, 0,           1, 32'h0000_0010, 1, D3,  32'hC));          // c14
        tbl.push_back(mk(0, 1, D4,  1, 0, 0,           0, 32'h0000_0010, 0, D3,  32'hC));          // c15
        tbl.push_back(mk(0, 0, 0,   1, 0, 0,           1, 32'h0000_0014, 1, D4,  32'h10));         // c16 no gnt
        tbl.push_back(mk(0, 0, 0,   1, 0, 0,           1, 32'h0000_0014, 0, D4,  32'h10));         // c17
        tbl.push_back(mk(1, 0, 0,   1, 0, 0,           1, 32'h0000_0014, 0, D4,  32'h10));         // c18
        tbl.push_back(mk(0, 0, 0,   1, 1, 32'h0000_0103, 0, 32'h0000_0014, 0, D4, 32'h10));        // c19 redirect in WAIT
        tbl.push_back(mk(0, 0, 0,   1, 0, 0,           0, 32'h0000_0100, 0, NOP, 32'h10));         // c20 DRAIN
        tbl.push_back(mk(0, 1, BAD, 1, 0, 0,           0, 32'h0000_0100, 0, NOP, 32'h10));         // c21 late rsp
        tbl.push_back(mk(1, 0, 0,   1, 0, 0,           1, 32'h0000_0100, 0, NOP, 32'h10));         // c22
        tbl.push_back(mk(0, 1, D5,  1, 0, 0,           0, 32'h0000_0100, 0, NOP, 32'h10));         // c23
        tbl.push_back(mk(1, 0, 0,   0, 0, 0,           1, 32'h0000_0104, 1, D5,  32'h100));        // c24
        tbl.push_back(mk(0, 1, BAD, 0, 1, 32'h0000_0200, 0, 32'h0000_0104, 1, D5, 32'h100));       // c25 redirect+rvalid
        tbl.push_back(mk(0, 0, 0,   1, 1, 32'hFFFF_FFFC, 1, 32'h0000_0200, 0, NOP, 32'h100));      // c26 redirect in REQ
        tbl.push_back(mk(1, 0, 0,   1, 0, 0,           1, 32'hFFFF_FFFC, 0, NOP, 32'h100));        // c27
        tbl.push_back(mk(0, 1, D6,  1, 0, 0,           0, 32'hFFFF_FFFC, 0, NOP, 32'h100));        // c28
        tbl.push_back(mk(0, 0, 0,   0, 0, 0,           1, 32'h0000_0000, 1, D6,  32'hFFFF_FFFC));  // c29 wrapped

        repeat (2) @(negedge clk);
        chk_a("reset", 0, 32'h0, 0, NOP, 32'h0);
        chk("reset.b_addr", b_addr, BPC);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < tbl.size(); i++) begin
            if (i > 0) @(negedge clk);
            chk_a($sformatf("c%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_valid,
                  tbl[i].e_instr, tbl[i].e_pc);
            drive(tbl[i].gnt, tbl[i].rv, tbl[i].rdata, tbl[i].rdy, tbl[i].rdr, tbl[i].rpc);
        end

        // Get dut into WAIT, then pulse reset between clock edges.
        @(negedge clk);
        drive(1, 0, 32'h0, 0, 0, 32'h0);
        @(negedge clk);
        chk("rw.req", 32'(a_req), 32'd0);
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk_a("async_rst", 0, 32'h0, 0, NOP, 32'h0);
        chk("async_rst.b_addr",  b_addr,       BPC);
        chk("async_rst.b_req",   32'(b_req),   32'd0);
        chk("async_rst.b_valid", 32'(b_valid), 32'd0);
        chk("async_rst.b_instr", b_instr,      NOP);

        @(negedge clk);
        rst_n = 1'b1;
        chk("rel.b_req", 32'(b_req), 32'd0);
        @(negedge clk);
        chk("rel.b_req1",  32'(b_req), 32'd1);
        chk("rel.b_addr1", b_addr,     BPC);
        drive(1, 0, 32'h0, 1, 0, 32'h0);
        @(negedge clk);
        chk("rel.b_wait", 32'(b_req), 32'd0);
        drive(0, 1, D7, 1, 0, 32'h0);
        @(negedge clk);
        chk("rel.b_valid", 32'(b_valid), 32'd1);
        chk("rel.b_instr", b_instr,      D7);
        chk("rel.b_pc",    b_pc,         BPC);
        chk("rel.b_addr2", b_addr,       BPC + 32'd4);
        drive(0, 0, 32'h0, 1, 0, 32'h0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage of the RV32 core; sits directly upstream of decode and the immediate extender.
- Owns the PC and issues word requests to instruction memory over a req/gnt + rvalid bus, one request outstanding at a time.
- Presents Instr/InstrPC with a valid/ready handshake; Instr feeds the extender's Instr input, and InstrPC feeds the branch/jump target adder.
- Accepts redirects (branch/jump target), squashing all in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset; bits [1:0] must be 0.
- XLEN, 32, address/data width; only 32 is supported.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ImemReq  out  1  fetch request
- ImemAddr  out  XLEN  word address of the request; [1:0] always 0
- ImemGnt  in  1  request accepted this cycle when ImemReq=1
- ImemRvalid  in  1  response data valid; earliest one cycle after the grant, arbitrary latency
- ImemRdata  in  32  instruction word
- Instr  out  32  instruction to decode/extender
- InstrPC  out  XLEN  PC of Instr
- InstrValid  out  1  Instr/InstrPC valid
- InstrReady  in  1  decode accepts; transfer occurs when InstrValid && InstrReady
- Redirect  in  1  flush and restart fetch
- RedirectPC  in  XLEN  new PC; bits [1:0] are forced to 0 internally

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - PC=RESET_PC, state=IDLE, ImemReq=0, ImemAddr=RESET_PC.
  - InstrValid=0, Instr=NOP_INSTR (32'h0000_0013), InstrPC=0.
  - Hold buffer empty; Kill=0.
- States:
  - IDLE: single cycle after reset release; always goes to REQ.
  - REQ: ImemReq=1, ImemAddr=PC. On ImemGnt go to WAIT, otherwise stay. The bus permits ImemAddr to change while ungranted.
  - WAIT: wait for ImemRvalid. On rvalid:
    - If the output slot is empty or drains this cycle: load Instr=ImemRdata, InstrPC=PC, InstrValid=1, PC+=4, go REQ.
    - Otherwise: store data/PC into the hold buffer, PC+=4, go HOLD.
  - HOLD: ImemReq=0. When the output transfers, move the buffer into the output slot and go REQ.
  - DRAIN: response still owed for a killed request. Discard on ImemRvalid and go REQ.
- Peak throughput is one instruction per 2 cycles (REQ+gnt, then rvalid next cycle); no prefetch beyond one.
- PC increments by 4 with 32-bit wrap (32'hFFFF_FFFC -> 0).
- Redirect (highest priority, any state except IDLE):
  - PC <= {RedirectPC[31:2],2'b00}.
  - InstrValid <= 0 and Instr <= NOP_INSTR; hold buffer cleared.
  - A transfer completing in the redirect cycle still counts as completed.
  - Next state depends on where the redirect lands:
    - REQ without gnt: stay in REQ; ImemAddr shows the new PC next cycle.
    - REQ with gnt, or WAIT without rvalid: go DRAIN.
    - WAIT with rvalid: data discarded, go REQ.
    - HOLD: go REQ.
    - DRAIN: stay DRAIN with the new PC.
  - Redirect during IDLE: PC updated, go REQ.
- Output stability: Instr/InstrPC/InstrValid hold unchanged while InstrValid=1 && InstrReady=0, unless Redirect.
- ImemRvalid outside WAIT/DRAIN is a protocol error; it is ignored.
- Reset mid-transaction returns everything to reset values immediately; the memory side must also be reset.

Decomposition:
- Shared package riscv_pkg:
  - NOP_INSTR constant.
  - Fetch state enum (IDLE, REQ, WAIT, HOLD, DRAIN).
  - Immediate-select encodings IMM_I=0, IMM_S=1, IMM_B=2, IMM_U=3 (used by decode, consumed by the extender).
- One sub-module, fetch_hold_reg: single-entry data+PC buffer with load/unload/clear.
- FSM and PC stay in instr_fetch.

Test Plan:
- Reset release, memory gnt same cycle, rvalid +1, InstrReady=1:
  - ImemAddr sequence is 0x0, 0x4, 0x8.
  - Instr outputs match rdata with InstrPC 0x0, 0x4, 0x8, one valid every 2 cycles.
- InstrReady=0 for 6 cycles after the first instruction:
  - Instr@0x0 held stable, second word captured in HOLD, ImemReq=0.
  - On InstrReady=1, 0x4 is presented next cycle; fetch of 0x8 follows.
- Redirect to 0x0000_0103 while in WAIT (rvalid 3 cycles later):
  - Late response discarded, never shown on Instr.
  - Next ImemAddr=0x0000_0100; InstrValid=0 until its data returns.
- Redirect in the same cycle as ImemRvalid in WAIT: data dropped, and the next request goes to RedirectPC with no DRAIN cycle.
- PC=0xFFFF_FFFC fetched: the next ImemAddr is 0x0000_0000.
- rst_n pulsed low during WAIT:
  - Outputs return to reset values asynchronously.
  - After release, the first ImemAddr is RESET_PC (run with RESET_PC=0x8000_0000).
